mem_arbiter: RTL



---
 rtl/mem_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the I-fetch and load/store requesters.
// A watchdog aborts transactions that memory never answers and reports them as errors.
module mem_arbiter #(
   parameter int unsigned TIMEOUT = 64,
   parameter int unsigned CNT_W   = 7
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_read,
   input  logic [15:0] i_address,
   output logic [15:0] i_rdata,
   output logic        i_resp,
   output logic        i_err,
   input  logic        d_read,
   input  logic        d_write,
   input  logic [15:0] d_address,
   input  logic [15:0] d_wdata,
   input  logic [1:0]  d_byte_enable,
   output logic [15:0] d_rdata,
   output logic        d_resp,
   output logic        d_err,
   output logic        mem_read,
   output logic        mem_write,
   output logic [15:0] mem_address,
   output logic [15:0] mem_wdata,
   output logic [1:0]  mem_byte_enable,
   input  logic [15:0] mem_rdata,
   input  logic        mem_resp
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] SERVE_I = 2'd1;
   localparam logic [1:0] SERVE_D = 2'd2;
   localparam logic [1:0] RECOVER = 2'd3;

   logic [1:0]       state_q, state_d;
   logic             last_d_q, last_d_d;  // 1: D-port was granted most recently
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic i_req, d_req, serve_i, serve_d, in_serve, req_held, done, timeout;

   assign i_req    = i_read;
   assign d_req    = d_read | d_write;
   assign serve_i  = (state_q == SERVE_I);
   assign serve_d  = (state_q == SERVE_D);
   assign in_serve = serve_i | serve_d;
   assign req_held = serve_i ? i_req : d_req;
   assign done     = in_serve & req_held & mem_resp;
   assign timeout  = in_serve & req_held & ~mem_resp & (cnt_q == CNT_W'(TIMEOUT - 1));

   always_comb begin
      mem_read        = 1'b0;
      mem_write       = 1'b0;
      mem_address     = 16'h0000;
      mem_wdata       = 16'h0000;
      mem_byte_enable = 2'b11;
      if (serve_i) begin
         mem_read    = i_read;
         mem_address = i_address;
      end else if (serve_d) begin
         // A simultaneous read and write resolves to the read
         mem_read        = d_read;
         mem_write       = d_write & ~d_read;
         mem_address     = d_address;
         mem_wdata       = d_wdata;
         mem_byte_enable = d_byte_enable;
      end
   end

   always_comb begin
      i_resp  = rst_n & serve_i & (done | timeout);
      i_err   = rst_n & serve_i & timeout;
      i_rdata = (rst_n & serve_i & done) ? mem_rdata : 16'h0000;
      d_resp  = rst_n & serve_d & (done | timeout);
      d_err   = rst_n & serve_d & timeout;
      d_rdata = (rst_n & serve_d & done) ? mem_rdata : 16'h0000;
   end

   always_comb begin
      state_d  = state_q;
      last_d_d = last_d_q;
      cnt_d    = cnt_q;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (i_req && (!d_req || last_d_q)) begin
               state_d = SERVE_I;
            end else if (d_req) begin
               state_d = SERVE_D;
            end
         end
         SERVE_I, SERVE_D: begin
            if (!req_held) begin
               state_d = RECOVER;
            end else if (done) begin
               state_d  = IDLE;
               last_d_d = serve_d;
            end else if (timeout) begin
               state_d  = RECOVER;
               last_d_d = serve_d;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RECOVER: begin
            // Hold here while a stale response is still on the bus
            if (!mem_resp) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         last_d_q <= 1'b1;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         last_d_q <= last_d_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule
